// File: rtl/input_capture_unit.sv
// Input-capture stage of the 16-bit timer/counter.
// Synchronises and digitally filters the external capture pin, detects the
// selected edge and latches the live counter value. It also tracks whether a
// captured value is still unread and flags overruns.
module input_capture_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int DATA_W      = 16
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_cap_en,
    input  logic              i_cap_clr,
    input  logic              i_cap_pin,
    input  logic [1:0]        i_edge_sel,
    input  logic [DATA_W-1:0] i_cnt_data,
    input  logic              i_cap_ack,
    output logic              o_cap_ic_flg,
    output logic [DATA_W-1:0] o_cap_cnt_data,
    output logic              o_cap_pend,
    output logic              o_cap_ovr
);

    // The extra bit keeps FILT_LEN=1 legal, where $clog2 would give 0 bits.
    localparam int CNT_W = $clog2(FILT_LEN) + 1;
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_out;
    logic                   filt_lvl;
    logic [CNT_W-1:0]       filt_cnt;
    logic                   toggle;
    logic                   rise;
    logic                   fall;
    logic                   hit;

    assign sync_out = sync_ff[SYNC_STAGES-1];

    // Shift the asynchronous pin through the synchroniser chain every cycle.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], i_cap_pin};
        end
    end

    // Accept a new pin level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            filt_lvl <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_out == filt_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_MAX) begin
            filt_lvl <= sync_out;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Qualify the filtered transition against enable, clear and edge select.
    always_comb begin
        toggle = (sync_out != filt_lvl) && (filt_cnt == FILT_MAX);
        rise   = toggle & sync_out;
        fall   = toggle & ~sync_out;
        hit    = i_cap_en & ~i_cap_clr &
                 ((i_edge_sel[0] & rise) | (i_edge_sel[1] & fall));
    end

    // Latch the counter on a hit and maintain the pending/overrun status.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst || i_cap_clr) begin
            o_cap_cnt_data <= '0;
            o_cap_ic_flg   <= 1'b0;
            o_cap_pend     <= 1'b0;
            o_cap_ovr      <= 1'b0;
        end else if (hit) begin
            o_cap_cnt_data <= i_cnt_data;
            o_cap_ic_flg   <= 1'b1;
            o_cap_pend     <= 1'b1;
            // An ack in the same cycle means the previous value was consumed.
            if (o_cap_pend && !i_cap_ack) begin
                o_cap_ovr <= 1'b1;
            end
        end else begin
            o_cap_ic_flg <= 1'b0;
            if (i_cap_ack) begin
                o_cap_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_capture_unit.sv
// Directed self-checking bench for input_capture_unit with default parameters.
module tb_input_capture_unit;

    logic        i_sysclk = 1'b0;
    logic        i_sysrst;
    logic        i_cap_en;
    logic        i_cap_clr;
    logic        i_cap_pin;
    logic [1:0]  i_edge_sel;
    logic [15:0] i_cnt_data;
    logic        i_cap_ack;
    logic        o_cap_ic_flg;
    logic [15:0] o_cap_cnt_data;
    logic        o_cap_pend;
    logic        o_cap_ovr;

    int tests_run = 0;
    int tests_failed = 0;

    input_capture_unit #(
        .SYNC_STAGES(2),
        .FILT_LEN   (4),
        .DATA_W     (16)
    ) dut (
        .i_sysclk      (i_sysclk),
        .i_sysrst      (i_sysrst),
        .i_cap_en      (i_cap_en),
        .i_cap_clr     (i_cap_clr),
        .i_cap_pin     (i_cap_pin),
        .i_edge_sel    (i_edge_sel),
        .i_cnt_data    (i_cnt_data),
        .i_cap_ack     (i_cap_ack),
        .o_cap_ic_flg  (o_cap_ic_flg),
        .o_cap_cnt_data(o_cap_cnt_data),
        .o_cap_pend    (o_cap_pend),
        .o_cap_ovr     (o_cap_ovr)
    );

    // Free-running system clock, 10 time units per period.
    always #5 i_sysclk = ~i_sysclk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Set the quasi-static control inputs.
    task automatic applyStimulus(input logic en, input logic [1:0] sel);
        i_cap_en   = en;
        i_edge_sel = sel;
    endtask

    // Advance one rising edge; outputs are stable at the following falling edge.
    // The counter value advances by one per cycle like the real counter core.
    task automatic tick();
        @(negedge i_sysclk);
        i_cnt_data = i_cnt_data + 16'd1;
    endtask

    // Drive a pin level for n cycles, optionally pulsing ack or clr at cycle
    // ack_at / clr_at, and record flags and the counter value of the first hit.
    task automatic run_edge(input logic pin_val, input int n, input int ack_at,
                            input int clr_at, output int n_flags,
                            output int first_idx, output logic [15:0] hit_data);
        logic [15:0] cnt_before;
        n_flags   = 0;
        first_idx = 0;
        hit_data  = '0;
        i_cap_pin = pin_val;
        for (int i = 1; i <= n; i++) begin
            i_cap_ack  = (i == ack_at);
            i_cap_clr  = (i == clr_at);
            cnt_before = i_cnt_data;
            tick();
            if (o_cap_ic_flg) begin
                n_flags++;
                if (first_idx == 0) begin
                    first_idx = i;
                    hit_data  = cnt_before;
                end
            end
        end
        i_cap_ack = 1'b0;
        i_cap_clr = 1'b0;
    endtask

    // Pulse the pin high for width cycles inside a 16-cycle window.
    task automatic run_pulse(input int width, output int n_flags,
                             output int idx_a, output int idx_b);
        n_flags = 0;
        idx_a   = 0;
        idx_b   = 0;
        for (int i = 1; i <= 16; i++) begin
            i_cap_pin = (i <= width);
            tick();
            if (o_cap_ic_flg) begin
                n_flags++;
                if (idx_a == 0) idx_a = i;
                else            idx_b = i;
            end
        end
    endtask

    int          nf;
    int          idx;
    int          idx_b;
    logic [15:0] hd;
    logic [15:0] saved;

    // Directed test sequence.
    initial begin
        i_sysrst   = 1'b1;
        i_cap_clr  = 1'b0;
        i_cap_pin  = 1'b0;
        i_cap_ack  = 1'b0;
        i_cnt_data = 16'h0000;
        applyStimulus(1'b0, 2'b00);
        tick();
        tick();
        checkOutput("rst_flg", 32'(o_cap_ic_flg), 32'd0);
        checkOutput("rst_data", 32'(o_cap_cnt_data), 32'd0);
        checkOutput("rst_pend", 32'(o_cap_pend), 32'd0);
        checkOutput("rst_ovr", 32'(o_cap_ovr), 32'd0);
        i_sysrst = 1'b0;
        tick();
        tick();

        // Latency: rising edge captured on edge 6.
        applyStimulus(1'b1, 2'b01);
        i_cnt_data = 16'h0100;
        i_cap_pin  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checkOutput($sformatf("lat_flg_%0d", i), 32'(o_cap_ic_flg), 32'(i == 6));
            if (i == 6) begin
                checkOutput("lat_data", 32'(o_cap_cnt_data), 32'h0105);
                checkOutput("lat_pend", 32'(o_cap_pend), 32'd1);
                checkOutput("lat_ovr", 32'(o_cap_ovr), 32'd0);
            end
        end
        i_cap_ack = 1'b1;
        tick();
        i_cap_ack = 1'b0;
        checkOutput("ack_pend", 32'(o_cap_pend), 32'd0);

        // Glitch rejection and minimum accepted pulse with both edges.
        applyStimulus(1'b1, 2'b11);
        run_edge(1'b0, 10, 0, 0, nf, idx, saved);
        checkOutput("both_fall_n", 32'(nf), 32'd1);
        checkOutput("both_fall_idx", 32'(idx), 32'd6);
        i_cap_ack = 1'b1;
        tick();
        i_cap_ack = 1'b0;
        run_pulse(3, nf, idx, idx_b);
        checkOutput("glitch_n", 32'(nf), 32'd0);
        checkOutput("glitch_data", 32'(o_cap_cnt_data), 32'(saved));
        run_pulse(4, nf, idx, idx_b);
        checkOutput("pulse4_n", 32'(nf), 32'd2);
        checkOutput("pulse4_rise", 32'(idx), 32'd6);
        checkOutput("pulse4_fall", 32'(idx_b), 32'd10);
        checkOutput("pulse4_ovr", 32'(o_cap_ovr), 32'd1);

        // Clear wipes the sticky overrun and captured state.
        i_cap_clr = 1'b1;
        tick();
        i_cap_clr = 1'b0;
        checkOutput("clr_data", 32'(o_cap_cnt_data), 32'd0);
        checkOutput("clr_pend", 32'(o_cap_pend), 32'd0);
        checkOutput("clr_ovr", 32'(o_cap_ovr), 32'd0);

        // Overrun: two rising captures without ack.
        applyStimulus(1'b1, 2'b01);
        run_edge(1'b1, 10, 0, 0, nf, idx, hd);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        checkOutput("ovr_nofall", 32'(nf), 32'd0);
        run_edge(1'b1, 10, 0, 0, nf, idx, hd);
        checkOutput("ovr_flag", 32'(o_cap_ovr), 32'd1);
        checkOutput("ovr_data", 32'(o_cap_cnt_data), 32'(hd));
        checkOutput("ovr_pend", 32'(o_cap_pend), 32'd1);
        i_cap_clr = 1'b1;
        tick();
        i_cap_clr = 1'b0;

        // Ack in the same cycle as the second hit prevents overrun.
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        run_edge(1'b1, 10, 0, 0, nf, idx, hd);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        run_edge(1'b1, 10, 6, 0, nf, idx, hd);
        checkOutput("ackhit_n", 32'(nf), 32'd1);
        checkOutput("ackhit_ovr", 32'(o_cap_ovr), 32'd0);
        checkOutput("ackhit_pend", 32'(o_cap_pend), 32'd1);
        checkOutput("ackhit_data", 32'(o_cap_cnt_data), 32'(hd));

        // Edge select: falling only, then none.
        applyStimulus(1'b1, 2'b00);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        checkOutput("sel00_a", 32'(nf), 32'd0);
        applyStimulus(1'b1, 2'b10);
        run_edge(1'b1, 10, 0, 0, nf, idx, hd);
        checkOutput("sel10_rise", 32'(nf), 32'd0);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        checkOutput("sel10_fall_n", 32'(nf), 32'd1);
        checkOutput("sel10_fall_idx", 32'(idx), 32'd6);
        applyStimulus(1'b1, 2'b00);
        run_edge(1'b1, 10, 0, 0, nf, idx, hd);
        checkOutput("sel00_rise", 32'(nf), 32'd0);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        checkOutput("sel00_fall", 32'(nf), 32'd0);

        // Enabling mid-level gives no spurious edge.
        applyStimulus(1'b0, 2'b10);
        run_edge(1'b1, 20, 0, 0, nf, idx, hd);
        checkOutput("dis_n", 32'(nf), 32'd0);
        applyStimulus(1'b1, 2'b10);
        run_edge(1'b1, 10, 0, 0, nf, idx, hd);
        checkOutput("en_mid_n", 32'(nf), 32'd0);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        checkOutput("en_fall_n", 32'(nf), 32'd1);
        checkOutput("en_fall_data", 32'(o_cap_cnt_data), 32'(hd));

        // Clear in the hit cycle suppresses the capture.
        applyStimulus(1'b1, 2'b01);
        run_edge(1'b1, 10, 0, 6, nf, idx, hd);
        checkOutput("clrhit_n", 32'(nf), 32'd0);
        checkOutput("clrhit_data", 32'(o_cap_cnt_data), 32'd0);
        checkOutput("clrhit_pend", 32'(o_cap_pend), 32'd0);
        checkOutput("clrhit_ovr", 32'(o_cap_ovr), 32'd0);

        // Reset while a capture is pending.
        applyStimulus(1'b1, 2'b11);
        run_edge(1'b0, 10, 0, 0, nf, idx, hd);
        checkOutput("pre_rst_pend", 32'(o_cap_pend), 32'd1);
        i_sysrst = 1'b1;
        tick();
        i_sysrst = 1'b0;
        checkOutput("mid_rst_flg", 32'(o_cap_ic_flg), 32'd0);
        checkOutput("mid_rst_data", 32'(o_cap_cnt_data), 32'd0);
        checkOutput("mid_rst_pend", 32'(o_cap_pend), 32'd0);
        checkOutput("mid_rst_ovr", 32'(o_cap_ovr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
